prim_req_collector_16: RTL
==========================

Name: prim_req_collector_16

Overview:
- Upstream request-collection stage for the 16-to-4 priority encoder.
- Captures single-cycle request pulses from 16 sources into a sticky pending register and masks them.
- Selects the highest-index eligible pending request and presents its 4-bit index in a registered valid/ready output stage.
- Removes each request from pending when it moves to the output stage; flags requests lost because their bit was already pending.

Parameters:
- none: width is fixed at 16 sources / 4-bit index, matching the downstream encoder.

Ports:
- i_clk  input  1  clock, all state updates on rising edge
- i_rst  input  1  asynchronous, active-high reset
- i_req  input  16  request pulses; bit k high for one cycle = one request from source k
- i_mask  input  16  bit k high = source k not eligible for selection (still captured into pending)
- i_ovf_clr  input  1  clears sticky overflow flag
- o_valid  output  1  output stage holds a request
- o_idx  output  4  index of request in output stage
- i_ready  input  1  consumer accepts o_idx when o_valid && i_ready
- o_pending  output  16  current pending register (debug/status)
- o_ovf  output  1  sticky: at least one request dropped
- o_busy  output  1  |o_pending or o_valid

Behaviour:
- Reset (async, i_rst=1): pending=16'h0, o_valid=0, o_idx=4'h0, o_ovf=0. All outputs hold these values while i_rst is high.
- Reset mid-operation discards all pending and in-flight requests immediately. The first edge after release behaves as from empty.
- Eligible vector: elig = pending & ~i_mask.
- Select rule: sel_idx = highest set bit index of elig, e.g. elig=16'h0120 gives sel_idx=8. sel_any = |elig.
- Load condition: load = sel_any && (!o_valid || i_ready). Loading is allowed while the current output is accepted in the same cycle, so back-to-back throughput is one index per cycle.
- On load: o_valid<=1, o_idx<=sel_idx, and pending[sel_idx] is cleared.
- When o_valid && i_ready && !sel_any: o_valid<=0. o_idx keeps its last value.
- Stall rule: while o_valid && !i_ready, o_idx and o_valid hold stable, no load occurs, and pending is not cleared.
- Pending update each edge: pending_next = (pending & ~clr_vec) | i_req, where clr_vec is the one-hot of sel_idx when load, else 0.
- Same-cycle set/clear: set wins. A new request on the bit being moved out stays pending, giving a second occurrence.
- Request for an index currently in the output stage: just pends, with no overflow.
- Overflow: o_ovf<=1 if any i_req[k]=1 while pending[k]=1 and bit k is not being cleared this cycle. The colliding request is dropped.
- Overflow precedence: i_ovf_clr=1 clears o_ovf, but a new overflow in the same cycle wins and o_ovf stays 1.
- Latency: a request pulse at edge N sets pending at N. With an empty output stage and an unmasked source, o_valid is high after edge N+1.
- Masking: a masked pending bit remains pending indefinitely and becomes eligible on the first cycle i_mask[k]=0.
- Changing i_mask never affects a request already in the output stage.
- No combinational path from i_req to o_valid/o_idx. i_ready affects only next-state, not outputs, in the same cycle.

Test Plan:
1. Reset, then i_req=16'h0001 for 1 cycle, i_ready=1 -> o_valid=1, o_idx=0 two edges after the pulse; next cycle o_valid=0, o_pending=0, o_busy=0.
2. i_req=16'h8421 one cycle, i_ready=1 -> o_idx sequence 15, 10, 5, 0 on consecutive cycles, then o_valid=0.
3. i_req=16'h0300, i_ready=0 for 5 cycles -> o_idx=9 held stable with o_pending=16'h0100. Raise i_ready -> o_idx=8 next, then o_valid=0.
4. i_req=16'h0010 twice on consecutive cycles with i_mask=16'h0010 -> o_ovf=1, o_pending=16'h0010, o_valid=0. Clear the mask -> o_idx=4. Pulse i_ovf_clr -> o_ovf=0.
5. Index 3 in output stage with i_ready=1 while i_req=16'h0008 arrives the same cycle -> no overflow; o_idx=3 is delivered twice.
6. Four requests pending and one in the output stage, assert i_rst asynchronously mid-cycle -> o_valid=0, o_pending=0, o_ovf=0 immediately. After release, i_req=16'h0040 -> o_idx=6.

Source files
------------

// File: rtl/prim_req_collector_16.sv
// prim_req_collector_16: collects single-cycle request pulses from 16 sources
// into a sticky pending register. The highest-index pending source that is not
// masked is moved into a registered valid/ready output stage as a 4-bit index.
module prim_req_collector_16 (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_req,
    input  logic [15:0] i_mask,
    input  logic        i_ovf_clr,
    output logic        o_valid,
    output logic [3:0]  o_idx,
    input  logic        i_ready,
    output logic [15:0] o_pending,
    output logic        o_ovf,
    output logic        o_busy
);
    localparam int NUM_SRC = 16;
    localparam int IDX_W   = 4;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } out_t;

    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] pending_next;
    logic [NUM_SRC-1:0] elig;
    logic [NUM_SRC-1:0] clr_vec;
    logic [NUM_SRC-1:0] ovf_hit;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_any;
    logic               load;
    logic               accept;
    out_t               out_q;

    assign elig    = pending & ~i_mask;
    assign sel_any = |elig;
    assign accept  = out_q.valid && i_ready;
    // A stalled output stage blocks loading, so the selected bit stays pending.
    assign load    = sel_any && (!out_q.valid || i_ready);
    assign clr_vec = load ? (NUM_SRC'(1) << sel_idx) : '0;

    // Scan upward so the highest set eligible bit is the one left in sel_idx.
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (elig[i]) sel_idx = IDX_W'(i);
        end
    end

    // Per-source next-state: a new request wins over the clear of the bit
    // being moved out, and a request on a bit that stays pending is dropped.
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_lane
        assign pending_next[k] = (pending[k] & ~clr_vec[k]) | i_req[k];
        assign ovf_hit[k]      = i_req[k] & pending[k] & ~clr_vec[k];
    end

    // Sticky pending register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) pending <= '0;
        else       pending <= pending_next;
    end

    // Output stage: load on free or draining slot, otherwise empty on accept.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            out_q <= '0;
        end else if (load) begin
            out_q.valid <= 1'b1;
            out_q.idx   <= sel_idx;
        end else if (accept) begin
            out_q.valid <= 1'b0;
        end
    end

    // Sticky overflow flag; a fresh drop beats a same-cycle clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)          o_ovf <= 1'b0;
        else if (|ovf_hit)  o_ovf <= 1'b1;
        else if (i_ovf_clr) o_ovf <= 1'b0;
    end

    assign o_valid   = out_q.valid;
    assign o_idx     = out_q.idx;
    assign o_pending = pending;
    assign o_busy    = (|pending) || out_q.valid;
endmodule
